// File: rtl/reset_ctrl.sv
// Reset sequencer: async assert / sync release of global_rst, warm resets, cause and count reporting.
// Optional watchdog reset enabled by defining RESET_CTRL_WDT_EN.
module reset_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int SW_HOLD_CYCLES = 4,
    parameter int CNT_W          = 8,
    parameter int WDT_CYCLES     = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_rst_req,
    input  logic             wdt_kick,
    output logic             global_rst,
    output logic             rst_done,
    output logic             sw_rst_ack,
    output logic [1:0]       rst_cause,
    output logic [CNT_W-1:0] rst_count
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    localparam int HOLD_MAX = (HOLD_CYCLES > SW_HOLD_CYCLES) ? HOLD_CYCLES : SW_HOLD_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   global_rst_q, global_rst_d;
    logic                   rst_done_q, rst_done_d;
    logic                   sw_rst_ack_q, sw_rst_ack_d;
    logic [1:0]             rst_cause_q, rst_cause_d;
    logic [CNT_W-1:0]       rst_count_q, rst_count_d;
    logic                   wdt_fire;

`ifdef RESET_CTRL_WDT_EN
    logic [WDT_W-1:0] wdt_q, wdt_d;

    // Counter only advances in RUN; a kick in the expiry cycle clears it instead of firing.
    always_comb begin
        wdt_d    = '0;
        wdt_fire = 1'b0;
        if (state_q == ST_RUN && !wdt_kick && !sw_rst_req) begin
            if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                wdt_fire = 1'b1;
            end else begin
                wdt_d = wdt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic [WDT_W-1:0] unused_wdt;
    assign unused_wdt = {WDT_W{wdt_kick}};
    assign wdt_fire   = 1'b0;
`endif

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], 1'b0};
        state_d      = state_q;
        hold_d       = hold_q;
        rst_done_d   = 1'b0;
        sw_rst_ack_d = 1'b0;
        rst_cause_d  = rst_cause_q;
        rst_count_d  = rst_count_q;
        case (state_q)
            // Move on the edge the synchronizer output goes low so release latency is SYNC_STAGES+HOLD_CYCLES.
            ST_SYNC: begin
                if (!sync_d[SYNC_STAGES-1]) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d    = ST_RUN;
                    hold_d     = '0;
                    rst_done_d = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_rst_req || wdt_fire) begin
                    state_d      = ST_HOLD;
                    hold_d       = HOLD_W'(SW_HOLD_CYCLES);
                    sw_rst_ack_d = sw_rst_req;
                    rst_cause_d  = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
                    if (rst_count_q != CNT_MAX) begin
                        rst_count_d = rst_count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
                hold_d  = '0;
            end
        endcase
        global_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '1;
            state_q      <= ST_SYNC;
            hold_q       <= '0;
            global_rst_q <= 1'b1;
            rst_done_q   <= 1'b0;
            sw_rst_ack_q <= 1'b0;
            rst_cause_q  <= CAUSE_EXT;
            rst_count_q  <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            global_rst_q <= global_rst_d;
            rst_done_q   <= rst_done_d;
            sw_rst_ack_q <= sw_rst_ack_d;
            rst_cause_q  <= rst_cause_d;
            rst_count_q  <= rst_count_d;
        end
    end

    assign global_rst = global_rst_q;
    assign rst_done   = rst_done_q;
    assign sw_rst_ack = sw_rst_ack_q;
    assign rst_cause  = rst_cause_q;
    assign rst_count  = rst_count_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: table-driven software-reset vectors plus hand-written reset/watchdog sequences.
// Watchdog checks run when RESET_CTRL_WDT_EN is defined.
module tb_reset_ctrl;

    localparam int SYNC_STAGES    = 2;
    localparam int HOLD_CYCLES    = 16;
    localparam int SW_HOLD_CYCLES = 4;
    localparam int CNT_W          = 2;
    localparam int WDT_CYCLES     = 64;
    localparam int REL            = SYNC_STAGES + HOLD_CYCLES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sw_rst_req = 1'b0;
    logic             wdt_kick = 1'b0;
    logic             global_rst;
    logic             rst_done;
    logic             sw_rst_ack;
    logic [1:0]       rst_cause;
    logic [CNT_W-1:0] rst_count;

    reset_ctrl #(
        .SYNC_STAGES    (SYNC_STAGES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .SW_HOLD_CYCLES (SW_HOLD_CYCLES),
        .CNT_W          (CNT_W),
        .WDT_CYCLES     (WDT_CYCLES)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .wdt_kick   (wdt_kick),
        .global_rst (global_rst),
        .rst_done   (rst_done),
        .sw_rst_ack (sw_rst_ack),
        .rst_cause  (rst_cause),
        .rst_count  (rst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             grst;
        logic             done;
        logic             ack;
        logic [1:0]       cause;
        logic [CNT_W-1:0] count;
    } exp_t;

    typedef struct {
        logic r;
        logic req;
        logic kick;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mkExp(string n, logic g, logic d, logic a, logic [1:0] c, logic [CNT_W-1:0] k);
        exp_t e;
        e.name  = n;
        e.grst  = g;
        e.done  = d;
        e.ack   = a;
        e.cause = c;
        e.count = k;
        return e;
    endfunction

    function automatic vec_t mkVec(logic req, exp_t e);
        vec_t v;
        v.r    = 1'b0;
        v.req  = req;
        v.kick = 1'b0;
        v.e    = e;
        return v;
    endfunction

    // Pop the oldest expectation and compare it with the current DUT outputs.
    task automatic checkOutput();
        exp_t             e;
        logic [4+CNT_W:0] act;
        logic [4+CNT_W:0] want;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got output with no expectation queued, required one");
            return;
        end
        e    = exp_q.pop_front();
        act  = {global_rst, rst_done, sw_rst_ack, rst_cause, rst_count};
        want = {e.grst, e.done, e.ack, e.cause, e.count};
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got grst=%b done=%b ack=%b cause=%b count=%0d, required grst=%b done=%b ack=%b cause=%b count=%0d",
                     e.name, global_rst, rst_done, sw_rst_ack, rst_cause, rst_count,
                     e.grst, e.done, e.ack, e.cause, e.count);
        end
    endtask

    // Drive inputs on the falling edge, queue the expectation for the following rising edge, check just after it.
    task automatic applyStimulus(input logic r, input logic req, input logic kick, input exp_t e);
        @(negedge clk);
        rst        = r;
        sw_rst_req = req;
        wdt_kick   = kick;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkNow(input exp_t e);
        exp_q.push_back(e);
        checkOutput();
    endtask

    task automatic releaseSeq(input string n);
        for (int i = 1; i <= REL; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, mkExp(n, (i < REL), (i == REL), 1'b0, 2'b00, '0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, mkExp({n, "_idle"}, 1'b0, 1'b0, 1'b0, 2'b00, '0));
    endtask

    task automatic holdTail(input string n, input logic [1:0] c, input logic [CNT_W-1:0] k);
        for (int i = 1; i < SW_HOLD_CYCLES; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, mkExp({n, "_hold"}, 1'b1, 1'b0, 1'b0, c, k));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, mkExp({n, "_done"}, 1'b0, 1'b1, 1'b0, c, k));
        applyStimulus(1'b0, 1'b0, 1'b0, mkExp({n, "_run"}, 1'b0, 1'b0, 1'b0, c, k));
    endtask

    task automatic swResetSeq(input string n, input logic [CNT_W-1:0] k);
        applyStimulus(1'b0, 1'b1, 1'b0, mkExp({n, "_ack"}, 1'b1, 1'b0, 1'b1, 2'b01, k));
        holdTail(n, 2'b01, k);
    endtask

    task automatic idleRun(input string n, input int cycles, input int kickEvery,
                           input logic [1:0] c, input logic [CNT_W-1:0] k);
        for (int i = 1; i <= cycles; i++) begin
            applyStimulus(1'b0, 1'b0, (kickEvery > 0) && (i % kickEvery == 0),
                          mkExp(n, 1'b0, 1'b0, 1'b0, c, k));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[11];
        exp_t rstExp;

        rstExp = mkExp("reset", 1'b1, 1'b0, 1'b0, 2'b00, '0);

        vecs[0]  = mkVec(1'b1, mkExp("sw1_ack",       1'b1, 1'b0, 1'b1, 2'b01, 2'd1));
        vecs[1]  = mkVec(1'b1, mkExp("sw1_hold_noack", 1'b1, 1'b0, 1'b0, 2'b01, 2'd1));
        vecs[2]  = mkVec(1'b1, mkExp("sw1_hold_noack", 1'b1, 1'b0, 1'b0, 2'b01, 2'd1));
        vecs[3]  = mkVec(1'b1, mkExp("sw1_hold_noack", 1'b1, 1'b0, 1'b0, 2'b01, 2'd1));
        vecs[4]  = mkVec(1'b1, mkExp("sw1_done",      1'b0, 1'b1, 1'b0, 2'b01, 2'd1));
        vecs[5]  = mkVec(1'b1, mkExp("sw2_reack",     1'b1, 1'b0, 1'b1, 2'b01, 2'd2));
        vecs[6]  = mkVec(1'b0, mkExp("sw2_hold",      1'b1, 1'b0, 1'b0, 2'b01, 2'd2));
        vecs[7]  = mkVec(1'b0, mkExp("sw2_hold",      1'b1, 1'b0, 1'b0, 2'b01, 2'd2));
        vecs[8]  = mkVec(1'b0, mkExp("sw2_hold",      1'b1, 1'b0, 1'b0, 2'b01, 2'd2));
        vecs[9]  = mkVec(1'b0, mkExp("sw2_done",      1'b0, 1'b1, 1'b0, 2'b01, 2'd2));
        vecs[10] = mkVec(1'b0, mkExp("sw2_run",       1'b0, 1'b0, 1'b0, 2'b01, 2'd2));

        $display("[TB] power-on");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, mkExp("por_held", 1'b1, 1'b0, 1'b0, 2'b00, '0));
        end
        releaseSeq("por_release");

        $display("[TB] software reset table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].r, vecs[i].req, vecs[i].kick, vecs[i].e);
        end

        $display("[TB] count saturation");
        swResetSeq("sat3", 2'd3);
        swResetSeq("sat4", 2'd3);
        swResetSeq("sat5", 2'd3);

        $display("[TB] reset mid-hold");
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp("ext_rst", 1'b1, 1'b0, 1'b0, 2'b00, '0));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, mkExp("midhold_pre", 1'b1, 1'b0, 1'b0, 2'b00, '0));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp("midhold_pulse", 1'b1, 1'b0, 1'b0, 2'b00, '0));
        releaseSeq("midhold_release");

        $display("[TB] sub-cycle glitch");
        swResetSeq("preglitch", 2'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkNow(mkExp("glitch_async", rstExp.grst, rstExp.done, rstExp.ack, rstExp.cause, rstExp.count));
        #1 rst = 1'b0;
        releaseSeq("glitch_release");

`ifdef RESET_CTRL_WDT_EN
        $display("[TB] watchdog");
        idleRun("wdt_nokick", WDT_CYCLES - 2, 0, 2'b00, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, mkExp("wdt_expire", 1'b1, 1'b0, 1'b0, 2'b10, 2'd1));
        holdTail("wdt", 2'b10, 2'd1);
        idleRun("wdt_kick50", 1000, 50, 2'b10, 2'd1);
        idleRun("wdt_prekick", WDT_CYCLES - 1, 0, 2'b10, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, mkExp("wdt_kick_expiry", 1'b0, 1'b0, 1'b0, 2'b10, 2'd1));
        idleRun("wdt_prereq", WDT_CYCLES - 1, 0, 2'b10, 2'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, mkExp("wdt_simul_ack", 1'b1, 1'b0, 1'b1, 2'b01, 2'd2));
        holdTail("wdt_simul", 2'b01, 2'd2);
`else
        $display("[TB] no watchdog");
        idleRun("no_wdt", 200, 0, 2'b00, '0);
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover expectations, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
